alu_rs: RTL
===========

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width (matches `dataWidth`).
REQ-002 SHALL have parameter TAG_W, default 4, ROB tag width (matches `tagWidth`).
REQ-003 SHALL have parameter RS_W, default 2, entry index width; entry count = 2**RS_W (matches `aluRSWidth`).
REQ-004 SHALL have parameter OP_W, default 4, ALU opcode width.
REQ-005 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port inValid, input, 1, dispatch request from decoder this cycle.
REQ-008 SHALL have ports inOp (input, OP_W), inDestTag (input, TAG_W): opcode and destination ROB tag.
REQ-009 SHALL have ports inRdy1/inRdy2 (input, 1), inVal1/inVal2 (input, DATA_W), inTag1/inTag2 (input, TAG_W): per-operand ready flag, value if ready, producer tag if not.
REQ-010 SHALL have port full, output, 1, no free entry; decoder must not dispatch.
REQ-011 SHALL have ports cdbValid (input, 1), cdbTag (input, TAG_W), cdbData (input, DATA_W): ALU result broadcast snooped for operand wakeup.
REQ-012 SHALL have ports finish (input, 1), finishRSNum (input, RS_W): ALU completion of the entry it names.
REQ-013 SHALL have ports issueValid (output, 1), issueOp (OP_W), issueA, issueB (DATA_W), issueTag (TAG_W), issueRSNum (RS_W): registered issue to ALU.

Function
REQ-014 SHALL keep per entry a state of FREE, WAIT or ISSUED, plus op, dest tag, two operands each {ready, tag, value}.
REQ-015 SHALL drive full = 1 iff no entry is FREE, computed from registered state only.
REQ-016 SHALL, on inValid=1 and full=0, write into the lowest-index FREE entry and set it WAIT; inValid while full=1 SHALL be ignored.
REQ-017 SHALL, on a dispatch whose operand is not ready and whose tag equals cdbTag with cdbValid=1 in the same cycle, store that operand as ready with cdbData.
REQ-018 SHALL, for every WAIT entry operand not ready with tag == cdbTag and cdbValid=1, set it ready with value cdbData at that edge.
REQ-019 SHALL each cycle select the lowest-index WAIT entry with both operands ready (registered state); at the edge, load issue outputs from it, set issueValid=1, and move it to ISSUED.
REQ-020 SHALL set issueValid=0 at an edge where no entry is selectable; at most one issue per cycle.
REQ-021 SHALL yield minimum latency dispatch-edge E (both ready) -> issueValid high after edge E+1; CDB wakeup at edge E -> issue at edge E+1 earliest.
REQ-022 SHALL, on finish=1, set entry finishRSNum to FREE at the edge; finish naming a non-ISSUED entry SHALL be ignored.
REQ-023 SHALL not reuse an entry freed by finish in the same cycle's dispatch (full reflects pre-edge state).
REQ-024 SHALL tolerate finish, dispatch, CDB wakeup and issue all in one cycle on distinct entries, each taking effect at that edge.

Reset
REQ-025 SHALL, on rst=1 at an edge, set all entries FREE, clear all operand fields, and drive issueValid=0, issueOp/issueA/issueB/issueTag/issueRSNum=0, full=0; in-flight WAIT/ISSUED entries SHALL be discarded.
REQ-026 SHALL ignore inValid, cdbValid and finish in any cycle with rst=1.

Verification
REQ-027 Dispatch op=3, A=5, B=7 ready, tag=2 into empty RS -> next edge issueValid=1, issueA=5, issueB=7, issueTag=2, issueRSNum=0; following edge issueValid=0.
REQ-028 Dispatch with src1 waiting tag=6; two cycles later cdbValid=1, cdbTag=6, cdbData=0x11 -> one edge later issue with issueA=0x11.
REQ-029 Dispatch src2 waiting tag=9 concurrently with cdbValid=1, cdbTag=9, cdbData=0xAB -> issue next edge with issueB=0xAB.
REQ-030 Fill 4 entries with unready operands -> full=1; extra inValid ignored; finish on entry 1 after its issue -> full=0 next cycle, next dispatch lands in entry 1.
REQ-031 Two entries become ready same edge (indices 2, 0) -> entry 0 issues first, entry 2 the next edge.
REQ-032 Assert rst with 3 entries WAIT/ISSUED -> after edge full=0, issueValid=0, all outputs 0; subsequent dispatch lands in entry 0.

Source files
------------

// File: rtl/alu_rs_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : alu_rs_if
// Description : Bundle of all non-clock signals of the ALU reservation station.
//               master = decoder/CDB/ALU side, slave = the reservation station.
//   Dispatch : inValid, inOp, inDestTag, inRdy1/2, inVal1/2, inTag1/2, full
//   Wakeup   : cdbValid, cdbTag, cdbData
//   Complete : finish, finishRSNum
//   Issue    : issueValid, issueOp, issueA, issueB, issueTag, issueRSNum
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface alu_rs_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int RS_W   = 2,
    parameter int OP_W   = 4
);
    logic              inValid;
    logic [OP_W-1:0]   inOp;
    logic [TAG_W-1:0]  inDestTag;
    logic              inRdy1;
    logic              inRdy2;
    logic [DATA_W-1:0] inVal1;
    logic [DATA_W-1:0] inVal2;
    logic [TAG_W-1:0]  inTag1;
    logic [TAG_W-1:0]  inTag2;
    logic              full;

    logic              cdbValid;
    logic [TAG_W-1:0]  cdbTag;
    logic [DATA_W-1:0] cdbData;

    logic              finish;
    logic [RS_W-1:0]   finishRSNum;

    logic              issueValid;
    logic [OP_W-1:0]   issueOp;
    logic [DATA_W-1:0] issueA;
    logic [DATA_W-1:0] issueB;
    logic [TAG_W-1:0]  issueTag;
    logic [RS_W-1:0]   issueRSNum;

    modport master (
        output inValid, inOp, inDestTag, inRdy1, inRdy2, inVal1, inVal2,
               inTag1, inTag2, cdbValid, cdbTag, cdbData, finish, finishRSNum,
        input  full, issueValid, issueOp, issueA, issueB, issueTag, issueRSNum
    );

    modport slave (
        input  inValid, inOp, inDestTag, inRdy1, inRdy2, inVal1, inVal2,
               inTag1, inTag2, cdbValid, cdbTag, cdbData, finish, finishRSNum,
        output full, issueValid, issueOp, issueA, issueB, issueTag, issueRSNum
    );
endinterface
`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : alu_rs
// Description : Reservation station for the ALU. Holds up to 2**RS_W
//               dispatched operations, wakes operands from the CDB, issues the
//               lowest-index ready entry per cycle and frees entries when the
//               ALU reports completion.
//   clk  : clock, all state changes on its rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_rs_if.slave (dispatch, CDB snoop, finish, registered issue)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module alu_rs #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int RS_W   = 2,
    parameter int OP_W   = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_rs_if.slave   bus
);
    localparam int c_ENTRIES = 2 ** RS_W;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ISSUED = 2'd2
    } entry_state_t;

    entry_state_t      r_state [c_ENTRIES];
    logic [OP_W-1:0]   r_op    [c_ENTRIES];
    logic [TAG_W-1:0]  r_dest  [c_ENTRIES];
    logic              r_rdy1  [c_ENTRIES];
    logic              r_rdy2  [c_ENTRIES];
    logic [TAG_W-1:0]  r_tag1  [c_ENTRIES];
    logic [TAG_W-1:0]  r_tag2  [c_ENTRIES];
    logic [DATA_W-1:0] r_val1  [c_ENTRIES];
    logic [DATA_W-1:0] r_val2  [c_ENTRIES];

    logic              r_issue_valid;
    logic [OP_W-1:0]   r_issue_op;
    logic [DATA_W-1:0] r_issue_a;
    logic [DATA_W-1:0] r_issue_b;
    logic [TAG_W-1:0]  r_issue_tag;
    logic [RS_W-1:0]   r_issue_rs;

    logic              w_free_found;
    logic [RS_W-1:0]   w_free_idx;
    logic              w_sel_found;
    logic [RS_W-1:0]   w_sel_idx;
    logic              w_dispatch;
    logic              w_fwd1;
    logic              w_fwd2;

    // Priority pickers over registered state only. Scanning from the top down
    // lets the last (lowest) hit overwrite earlier ones.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        for (int i = c_ENTRIES - 1; i >= 0; i--) begin
            if (r_state[i] == ST_FREE) begin
                w_free_found = 1'b1;
                w_free_idx   = RS_W'(i);
            end
            if (r_state[i] == ST_WAIT && r_rdy1[i] && r_rdy2[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = RS_W'(i);
            end
        end
    end

    // Because full is pre-edge state, an entry freed this cycle is not seen as
    // free until the next cycle.
    assign w_dispatch = bus.inValid & w_free_found;

    // A dispatched operand whose producer is broadcasting right now would miss
    // the wakeup otherwise, so capture the CDB value directly.
    assign w_fwd1 = !bus.inRdy1 && bus.cdbValid && (bus.inTag1 == bus.cdbTag);
    assign w_fwd2 = !bus.inRdy2 && bus.cdbValid && (bus.inTag2 == bus.cdbTag);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_state[i] <= ST_FREE;
                r_op[i]    <= '0;
                r_dest[i]  <= '0;
                r_rdy1[i]  <= 1'b0;
                r_rdy2[i]  <= 1'b0;
                r_tag1[i]  <= '0;
                r_tag2[i]  <= '0;
                r_val1[i]  <= '0;
                r_val2[i]  <= '0;
            end
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_a     <= '0;
            r_issue_b     <= '0;
            r_issue_tag   <= '0;
            r_issue_rs    <= '0;
        end else begin
            // The four actions below always target entries in different
            // states (ISSUED, WAIT-selected, WAIT, FREE), so they never collide.
            for (int i = 0; i < c_ENTRIES; i++) begin
                if (bus.finish && bus.finishRSNum == RS_W'(i) &&
                    r_state[i] == ST_ISSUED) begin
                    r_state[i] <= ST_FREE;
                end

                if (w_sel_found && w_sel_idx == RS_W'(i)) begin
                    r_state[i] <= ST_ISSUED;
                end

                if (r_state[i] == ST_WAIT && bus.cdbValid) begin
                    if (!r_rdy1[i] && r_tag1[i] == bus.cdbTag) begin
                        r_rdy1[i] <= 1'b1;
                        r_val1[i] <= bus.cdbData;
                    end
                    if (!r_rdy2[i] && r_tag2[i] == bus.cdbTag) begin
                        r_rdy2[i] <= 1'b1;
                        r_val2[i] <= bus.cdbData;
                    end
                end

                if (w_dispatch && w_free_idx == RS_W'(i)) begin
                    r_state[i] <= ST_WAIT;
                    r_op[i]    <= bus.inOp;
                    r_dest[i]  <= bus.inDestTag;
                    r_tag1[i]  <= bus.inTag1;
                    r_tag2[i]  <= bus.inTag2;
                    r_rdy1[i]  <= bus.inRdy1 | w_fwd1;
                    r_rdy2[i]  <= bus.inRdy2 | w_fwd2;
                    r_val1[i]  <= w_fwd1 ? bus.cdbData : bus.inVal1;
                    r_val2[i]  <= w_fwd2 ? bus.cdbData : bus.inVal2;
                end
            end

            // Payload holds its last value when nothing issues; only the
            // valid flag drops.
            r_issue_valid <= w_sel_found;
            if (w_sel_found) begin
                r_issue_op  <= r_op[w_sel_idx];
                r_issue_a   <= r_val1[w_sel_idx];
                r_issue_b   <= r_val2[w_sel_idx];
                r_issue_tag <= r_dest[w_sel_idx];
                r_issue_rs  <= w_sel_idx;
            end
        end
    end

    assign bus.full       = ~w_free_found;
    assign bus.issueValid = r_issue_valid;
    assign bus.issueOp    = r_issue_op;
    assign bus.issueA     = r_issue_a;
    assign bus.issueB     = r_issue_b;
    assign bus.issueTag   = r_issue_tag;
    assign bus.issueRSNum = r_issue_rs;
endmodule
`default_nettype wire
